demux_seq_driver: RTL
=====================

# demux_seq_driver

Upstream driver for the 1-to-8 demultiplexer stage. Accepts an 8-bit parallel word over a valid/ready handshake, then walks the demux select from channel 0 to channel 7, presenting one data bit per channel with the enable asserted. The demux's output bits therefore receive the word one bit at a time. A one-cycle completion pulse follows each word, and then the block accepts the next word.

## Interface
Parameters:
- DWELL, default 4: clock cycles each channel is held. Legal range ≥1. Used only when DEMUX_SEQ_DWELL_EN is defined.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- din  input  8  parallel word; din[i] is destined for demux channel i.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block can accept a word; high only in IDLE.
- D  output  1  serial data bit to demux.
- sel  output  3  demux channel select.
- EN  output  1  demux enable; high only while a channel is being driven.
- busy  output  1  high in SEND and DONE.
- done  output  1  single-cycle pulse after channel 7 completes.

## Operation
- Reset values: din_ready=1, D=0, sel=3'd0, EN=0, busy=0, done=0, state=IDLE.
- All outputs except din_ready are registered. din_ready is decoded from state (state==IDLE).
- States are IDLE, SEND and DONE.
- IDLE:
  - A transfer is accepted when din_valid && din_ready.
  - On acceptance, capture din into word_q, load D=din[0], set sel=0 and EN=1, and go to SEND.
- SEND:
  - D always equals word_q[sel].
  - At the end of each channel slot, if sel<7: sel increments and D=word_q[sel+1].
  - At the end of the sel==7 slot: EN=0, D=0, sel=0, done=1, go to DONE.
- DONE: lasts exactly one cycle. done returns to 0, then go to IDLE.
- din_valid while busy: ignored. Upstream must hold din/din_valid until din_ready is high (standard valid/ready rule).
- din changing while in SEND: no effect; only word_q is used.
- sel never wraps during a transfer. 7 is always the final channel, with no 7→0 step while EN=1.
- rst mid-transfer: next cycle is IDLE with reset values. EN drops immediately, no done pulse, and the partial word is discarded.
- Simultaneous rst and din_valid: rst wins and the word is not accepted.

## Timing
- Without dwell, for a handshake in cycle t:
  - Channel k (0..7) is driven (EN=1, sel=k, D=din[k]) in cycle t+1+k.
  - done=1 in cycle t+9.
  - din_ready=1 again in cycle t+10.
- Word period is 10 cycles back-to-back.
- With dwell, for a handshake in cycle t:
  - Channel k is driven in cycles t+1+k·DWELL through t+(k+1)·DWELL.
  - done=1 in cycle t+8·DWELL+1.
  - din_ready=1 in cycle t+8·DWELL+2.
- sel and D change only at slot boundaries. They are never glitch-updated mid-slot.

## Configuration
- Macro: DEMUX_SEQ_DWELL_EN.
- Defined:
  - A dwell counter of width $clog2(DWELL) (minimum 1) runs 0..DWELL-1 within each slot.
  - The slot ends when the counter reaches DWELL-1.
  - The counter resets to 0 on rst, on acceptance, and at each slot end.
  - DWELL=1 gives behaviour identical to the undefined case.
- Undefined: every slot is one cycle, the DWELL parameter is ignored, and no counter is instantiated.

## Structure
- Package demux_seq_pkg contains:
  - typedef enum of the state (IDLE, SEND, DONE).
  - NUM_CH=8.
  - SEL_W=3.
- Sub-module demux_seq_dwell_cnt:
  - Inputs: clk, rst, clear, en.
  - Output: slot_end.
  - Instantiated only under DEMUX_SEQ_DWELL_EN.
- Without the macro, slot_end is tied to 1.

## Test plan
- Reset then idle → after rst deasserts: din_ready=1, EN=0, sel=0, D=0, done=0, held indefinitely with din_valid=0.
- Macro off, din=8'hA5 handshake in cycle t:
  - Cycles t+1..t+8 show sel=0..7 with D=1,0,1,0,0,1,0,1 and EN=1.
  - done pulse at t+9; din_ready at t+10.
  - A downstream demux model ends with Y=8'hA5.
- Back-to-back words 8'hFF then 8'h00 with din_valid held high:
  - Second handshake occurs at t+10.
  - din_valid during t+1..t+9 is ignored.
  - A demux model shows Y=8'h00 after the second done.
- rst asserted in cycle t+4 of a transfer of 8'h3C:
  - Cycle t+5 shows EN=0, sel=0, busy=0, din_ready=1.
  - No done pulse occurs.
  - A new word is accepted normally afterwards.
- Macro on, DWELL=4, din=8'h81:
  - Each sel value is held 4 cycles with D stable.
  - EN is high for 32 cycles.
  - done at t+33; din_ready at t+34.
- Macro on, DWELL=1: cycle-identical output trace to the macro-off run with din=8'hA5.

Source files
------------

// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the 1-to-8 demux sequence driver.
package demux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

endpackage

// File: rtl/demux_seq_dwell_cnt.sv
// Per-channel dwell counter: flags the last cycle of each DWELL-cycle slot.
// Only instantiated when DEMUX_SEQ_DWELL_EN is defined.
module demux_seq_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic slot_end
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_reg;

  assign slot_end = (cnt_reg == CW'(DWELL - 1));

  // Wraps to zero on its own at slot end so consecutive slots need no extra clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= slot_end ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/demux_seq_driver.sv
// Serialises an 8-bit word onto a 1-to-8 demux, channel 0 first, one bit per slot.
// Define DEMUX_SEQ_DWELL_EN to hold each channel for DWELL cycles instead of one.
module demux_seq_driver
  import demux_seq_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             D,
  output logic [SEL_W-1:0] sel,
  output logic             EN,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  if (DWELL < 1) begin : g_illegal_dwell
    $error("demux_seq_driver: DWELL must be at least 1");
  end

  state_t             state_reg;
  logic [NUM_CH-1:0]  word_reg;
  logic               d_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic [SEL_W-1:0]   sel_next;
  logic               en_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               accept;
  logic               slot_end;

  assign din_ready = (state_reg == IDLE);
  assign accept    = din_valid && din_ready;
  assign sel_next  = sel_reg + 1'b1;

  assign D    = d_reg;
  assign sel  = sel_reg;
  assign EN   = en_reg;
  assign busy = busy_reg;
  assign done = done_reg;

`ifdef DEMUX_SEQ_DWELL_EN
  demux_seq_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (state_reg == SEND),
    .slot_end (slot_end)
  );
`else
  assign slot_end = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      d_reg     <= 1'b0;
      sel_reg   <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            word_reg  <= din;
            d_reg     <= din[0];
            sel_reg   <= '0;
            en_reg    <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= SEND;
          end
        end
        SEND: begin
          // sel and D only move on slot boundaries; channel 7 ends the word without wrapping.
          if (slot_end) begin
            if (sel_reg == LAST_CH) begin
              en_reg    <= 1'b0;
              d_reg     <= 1'b0;
              sel_reg   <= '0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              sel_reg <= sel_next;
              d_reg   <= word_reg[sel_next];
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          en_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
